multicycle_ctrl: RTL
====================

# multicycle_ctrl

Multi-cycle control FSM for the RV32I integer core (plus optional F-extension loads and stores). It sequences the shared datapath: PC, instruction register, immediate generator, ALU, data memory port and register files. It drives all mux selects and write enables from the opcode field inst[6:2], which is the same opcode encoding the immediate generator uses. It also watches the memory handshakes with a timeout counter.

## Interface
Parameters:
- MEM_TIMEOUT, default 255: maximum cycles any memory request may wait for ready; range 1..65535.

Ports:
- clk  in  1  core clock
- rst  in  1  reset, asynchronous, active-high
- inst  in  32  instruction register contents
- br_taken  in  1  branch comparison result from ALU, valid in EX
- imem_ready  in  1  instruction fetch complete, rdata valid this cycle
- dmem_ready  in  1  data access complete
- imem_req  out  1  fetch request
- ir_we  out  1  load instruction register
- pc_we  out  1  update PC
- pc_sel  out  2  0: pc+4, 1: pc+imm, 2: ALU result & ~1
- alu_a_sel  out  1  0: rs1, 1: pc
- alu_b_sel  out  1  0: rs2, 1: imm
- dmem_req  out  1  data request
- dmem_we  out  1  data write (store)
- wb_sel  out  2  0: ALU, 1: memory, 2: pc+4
- rf_we  out  1  integer register file write
- frf_we  out  1  FP register file write
- retire  out  1  one-cycle pulse per completed instruction
- illegal  out  1  sticky; set on entering TRAP
- timeout  out  1  sticky; set when a memory wait exceeds MEM_TIMEOUT
- state_o  out  3  current state encoding

## Operation
- States: IF=0, DEC=1, EX=2, MEM=3, WB=4, TRAP=5.
- IF: imem_req=1. On imem_ready, ir_we=1 in the same cycle, then go to DEC.
- DEC: one cycle, no side effects. If inst[1:0]!=2'b11 or the opcode is unsupported, go to TRAP. Otherwise go to EX.
- Per-class paths, keyed on inst[6:2]:
  - OP_IMM 00100, OP 01100: EX(a=0, b=1 for OP_IMM, b=0 for OP) -> WB(wb_sel=0, rf_we, pc_we, pc_sel=0).
  - LUI 01101, AUIPC 00101: EX(a=1, b=1) -> WB as above. The datapath zeroes operand a for LUI.
  - LOAD 00000: EX(a=0, b=1) -> MEM(dmem_req) -> WB(wb_sel=1, rf_we, pc_we, pc_sel=0).
  - STORE 01000: EX(a=0, b=1) -> MEM(dmem_req, dmem_we). On dmem_ready: pc_we, pc_sel=0, retire, go to IF.
  - BRANCH 11000: EX(a=0, b=0): pc_we=1, pc_sel=br_taken?1:0, retire, go to IF.
  - JAL 11011: EX -> WB(wb_sel=2, rf_we, pc_we, pc_sel=1).
  - JALR 11001: EX(a=0, b=1) -> WB(wb_sel=2, rf_we, pc_we, pc_sel=2).
- rf_we is suppressed when inst[11:7]==0. frf_we has no x0 rule.
- WB always asserts retire and returns to IF.
- Timeout counter:
  - Cleared on entering IF or MEM.
  - Increments each cycle the state waits without ready.
  - When the count reaches MEM_TIMEOUT with ready still low, set timeout and go to TRAP.
- TRAP: all enables and requests 0. It is terminal until rst.
- Selects outside their active states hold 0.

## Timing
- Reset values:
  - state=IF.
  - illegal=0, timeout=0.
  - All enables and requests 0.
  - All selects 0, except imem_req=1 in the first cycle after reset release.
- Outputs are decoded combinationally from the state register and the registered inst. There is no input-to-output path except:
  - ir_we from imem_ready;
  - pc_sel from br_taken;
  - dmem-completion actions from dmem_ready.
- Minimum latencies, with ready asserted on the first request cycle:
  - BRANCH: 3 cycles.
  - STORE: 4 cycles.
  - ALU, LUI, AUIPC, JAL, JALR: 4 cycles.
  - LOAD: 5 cycles.
- imem_req and dmem_req stay high from their first cycle until the cycle ready is seen. Ready with no request pending is ignored.
- Asserting rst mid-operation forces IF immediately and clears the sticky flags. No partial write may be issued after reset is asserted.
- The timeout counter is wide enough for MEM_TIMEOUT. If ready and the limit coincide in the same cycle, ready wins.

## Configuration
- Macro FPU_LS_EN.
- Defined:
  - LOAD_FP 00001 follows the LOAD path, but WB asserts frf_we instead of rf_we (wb_sel=1).
  - STORE_FP 01001 follows the STORE path.
- Undefined: both opcodes are illegal and go to TRAP from DEC. frf_we is tied to 0.

## Test plan
- addi x1,x0,5 (0x00500093), imem_ready on the first cycle -> states IF,DEC,EX,WB. In WB: rf_we=1, wb_sel=0, pc_we=1, pc_sel=0, retire=1. Next state IF.
- lw x2,0(x1) (0x0000A103), dmem_ready delayed 3 cycles -> dmem_req high 4 cycles, then WB with wb_sel=1, rf_we=1. Total 8 cycles.
- beq x0,x0,8 (0x00000463):
  - br_taken=1 in EX -> pc_sel=1, pc_we=1, retire=1. No WB state.
  - br_taken=0 -> pc_sel=0.
- sw x2,4(x1) (0x0020A223) with dmem_ready withheld, MEM_TIMEOUT=4 -> after 4 waiting cycles timeout=1 and state=TRAP. All outputs 0 until rst.
- Instruction 0x00000000 -> illegal=1, TRAP from DEC. Then pulse rst mid-TRAP -> state IF, illegal=0.
- flw f1,0(x1) (0x0000A087):
  - With FPU_LS_EN: WB asserts frf_we=1, rf_we=0.
  - Without FPU_LS_EN: illegal=1.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle sequencing FSM for an RV32I integer core.
// Drives the shared-datapath selects and write enables from inst[6:2] and
// watches both memory handshakes with a timeout counter.
// Optional F-extension loads/stores (LOAD_FP, STORE_FP) are enabled by
// defining the macro FPU_LS_EN; without it those opcodes trap as illegal
// and frf_we_o is tied low.
module multicycle_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst_i,
    input  logic        br_taken_i,
    input  logic        imem_ready_i,
    input  logic        dmem_ready_i,
    output logic        imem_req_o,
    output logic        ir_we_o,
    output logic        pc_we_o,
    output logic [1:0]  pc_sel_o,
    output logic        alu_a_sel_o,
    output logic        alu_b_sel_o,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [1:0]  wb_sel_o,
    output logic        rf_we_o,
    output logic        frf_we_o,
    output logic        retire_o,
    output logic        illegal_o,
    output logic        timeout_o,
    output logic [2:0]  state_o
);

    // Counter only needs to hold values up to MEM_TIMEOUT-1 before tripping.
    localparam int unsigned CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    localparam logic [2:0] S_IF   = 3'd0;
    localparam logic [2:0] S_DEC  = 3'd1;
    localparam logic [2:0] S_EX   = 3'd2;
    localparam logic [2:0] S_MEM  = 3'd3;
    localparam logic [2:0] S_WB   = 3'd4;
    localparam logic [2:0] S_TRAP = 3'd5;

    localparam logic [4:0] OPC_LOAD     = 5'b00000;
    localparam logic [4:0] OPC_LOAD_FP  = 5'b00001;
    localparam logic [4:0] OPC_OP_IMM   = 5'b00100;
    localparam logic [4:0] OPC_AUIPC    = 5'b00101;
    localparam logic [4:0] OPC_STORE    = 5'b01000;
    localparam logic [4:0] OPC_STORE_FP = 5'b01001;
    localparam logic [4:0] OPC_OP       = 5'b01100;
    localparam logic [4:0] OPC_LUI      = 5'b01101;
    localparam logic [4:0] OPC_BRANCH   = 5'b11000;
    localparam logic [4:0] OPC_JALR     = 5'b11001;
    localparam logic [4:0] OPC_JAL      = 5'b11011;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             illegal_q, illegal_d;
    logic             timeout_q, timeout_d;

    logic [4:0] opcode;
    logic       rd_nz;
    logic       is_load, is_store, is_fload;
    logic       is_branch, is_jal, is_jalr, is_lui, is_auipc, is_op_imm, is_op;
    logic       legal;
    logic       unused_inst;

    assign opcode      = inst_i[6:2];
    assign rd_nz       = |inst_i[11:7];
    assign unused_inst = ^inst_i[31:12];

    // Instruction class decode from the registered opcode.
    always_comb begin
        is_op_imm = (opcode == OPC_OP_IMM);
        is_op     = (opcode == OPC_OP);
        is_lui    = (opcode == OPC_LUI);
        is_auipc  = (opcode == OPC_AUIPC);
        is_branch = (opcode == OPC_BRANCH);
        is_jal    = (opcode == OPC_JAL);
        is_jalr   = (opcode == OPC_JALR);
        is_fload  = 1'b0;
        is_load   = (opcode == OPC_LOAD);
        is_store  = (opcode == OPC_STORE);
`ifdef FPU_LS_EN
        is_fload  = (opcode == OPC_LOAD_FP);
        is_load   = (opcode == OPC_LOAD) | (opcode == OPC_LOAD_FP);
        is_store  = (opcode == OPC_STORE) | (opcode == OPC_STORE_FP);
`else
        if ((opcode == OPC_LOAD_FP) || (opcode == OPC_STORE_FP)) begin
            is_load  = 1'b0;
            is_store = 1'b0;
        end
`endif
        legal = (inst_i[1:0] == 2'b11) &&
                (is_op_imm | is_op | is_lui | is_auipc | is_branch |
                 is_jal | is_jalr | is_load | is_store);
    end

    // Next-state, timeout counter and sticky flag update.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        illegal_d = illegal_q;
        timeout_d = timeout_q;

        case (state_q)
            S_IF: begin
                if (imem_ready_i) begin
                    state_d = S_DEC;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = S_TRAP;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DEC: begin
                state_d = legal ? S_EX : S_TRAP;
            end
            S_EX: begin
                if (is_branch) begin
                    state_d = S_IF;
                end else if (is_load || is_store) begin
                    state_d = S_MEM;
                end else if (is_op_imm || is_op || is_lui || is_auipc ||
                             is_jal || is_jalr) begin
                    state_d = S_WB;
                end else begin
                    state_d = S_TRAP;
                end
            end
            S_MEM: begin
                if (dmem_ready_i) begin
                    state_d = is_store ? S_IF : S_WB;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = S_TRAP;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WB: begin
                state_d = S_IF;
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_TRAP;
            end
        endcase

        // Every wait starts with a fresh budget.
        if (((state_d == S_IF) || (state_d == S_MEM)) && (state_d != state_q)) begin
            cnt_d = '0;
        end

        if ((state_d == S_TRAP) && (state_q != S_TRAP)) begin
            illegal_d = 1'b1;
        end
    end

    // State and sticky flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IF;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
        end
    end

    // Datapath controls decoded from state and IR; silenced while in reset.
    always_comb begin
        imem_req_o  = 1'b0;
        ir_we_o     = 1'b0;
        pc_we_o     = 1'b0;
        pc_sel_o    = 2'd0;
        alu_a_sel_o = 1'b0;
        alu_b_sel_o = 1'b0;
        dmem_req_o  = 1'b0;
        dmem_we_o   = 1'b0;
        wb_sel_o    = 2'd0;
        rf_we_o     = 1'b0;
        frf_we_o    = 1'b0;
        retire_o    = 1'b0;

        if (!rst) begin
            case (state_q)
                S_IF: begin
                    imem_req_o = 1'b1;
                    ir_we_o    = imem_ready_i;
                end
                S_EX: begin
                    alu_a_sel_o = is_lui | is_auipc;
                    alu_b_sel_o = is_op_imm | is_lui | is_auipc | is_load |
                                  is_store | is_jalr;
                    if (is_branch) begin
                        pc_we_o  = 1'b1;
                        pc_sel_o = br_taken_i ? 2'd1 : 2'd0;
                        retire_o = 1'b1;
                    end
                end
                S_MEM: begin
                    dmem_req_o = 1'b1;
                    dmem_we_o  = is_store;
                    if (is_store && dmem_ready_i) begin
                        pc_we_o  = 1'b1;
                        retire_o = 1'b1;
                    end
                end
                S_WB: begin
                    pc_we_o  = 1'b1;
                    retire_o = 1'b1;
                    if (is_load) begin
                        wb_sel_o = 2'd1;
                        rf_we_o  = rd_nz & ~is_fload;
                        frf_we_o = is_fload;
                    end else if (is_jal) begin
                        wb_sel_o = 2'd2;
                        pc_sel_o = 2'd1;
                        rf_we_o  = rd_nz;
                    end else if (is_jalr) begin
                        wb_sel_o = 2'd2;
                        pc_sel_o = 2'd2;
                        rf_we_o  = rd_nz;
                    end else begin
                        rf_we_o  = rd_nz;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign illegal_o = illegal_q;
    assign timeout_o = timeout_q;
    assign state_o   = state_q;

endmodule
